// File: rtl/jk_sync_up_counter_pkg.sv
// Shared defaults and JK encodings for the JK-based counters.
// Holds WIDTH/MODULUS defaults and the {J,K} pair codes.
package jk_sync_up_counter_pkg;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_MODULUS = 64;

  // {J,K} pair as driven into a jkff_sync stage
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_t;

endpackage

// File: rtl/jk_sync_up_counter_jkff_sync.sv
// jkff_sync: one JK flip-flop with synchronous active-high clr.
// Ports: clk, clr, j, k in; q, qnot out (both registered).
module jkff_sync
  import jk_sync_up_counter_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qnot
);

  logic q_q;
  logic qn_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      JK_SET:    q_d = 1'b1;
      JK_RESET:  q_d = 1'b0;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // qnot is its own register but always loaded with ~q_d,
  // so the pair cannot diverge, clr included.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q  <= 1'b0;
      qn_q <= 1'b1;
    end else begin
      q_q  <= q_d;
      qn_q <= ~q_d;
    end
  end

  assign q    = q_q;
  assign qnot = qn_q;

endmodule

// File: rtl/jk_sync_up_counter.sv
// Synchronous modulo-MODULUS up counter built from JK stages.
// In: clk, clr, en, load, d, ovf_clr. Out: q, qnot, tc, ovf.
module jk_sync_up_counter
  import jk_sync_up_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LAST =
    WIDTH'(MODULUS - 1);

  logic             at_last;
  logic             wrap;
  logic [WIDTH-1:0] cy;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  jk_t              sel;
  logic             ovf_k;
  logic             ovf_unused;

  // >= so an out-of-range loaded value wraps on the next enable
  assign at_last = (q >= LAST);
  assign tc      = en & at_last;
  assign wrap    = en & ~load & at_last;

  always_comb begin
    cy    = '0;
    j_d   = '0;
    k_d   = '0;
    sel   = JK_HOLD;
    // bit i toggles when en and all lower bits are 1
    cy[0] = en;
    for (int i = 1; i < WIDTH; i++) begin
      cy[i] = cy[i-1] & q[i-1];
    end
    for (int i = 0; i < WIDTH; i++) begin
      unique case (1'b1)
        load:    sel = d[i] ? JK_SET : JK_RESET;
        wrap:    sel = JK_RESET;
        default: sel = cy[i] ? JK_TOGGLE : JK_HOLD;
      endcase
      {j_d[i], k_d[i]} = sel;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff_sync u_ff (
      .clk  (clk),
      .clr  (clr),
      .j    (j_d[i]),
      .k    (k_d[i]),
      .q    (q[i]),
      .qnot (qnot[i])
    );
  end

  // wrap beats a simultaneous ovf_clr
  assign ovf_k = ovf_clr & ~wrap;

  jkff_sync u_ovf (
    .clk  (clk),
    .clr  (clr),
    .j    (wrap),
    .k    (ovf_k),
    .q    (ovf),
    .qnot (ovf_unused)
  );

endmodule

// File: tb/tb_jk_sync_up_counter.sv
// Testbench for jk_sync_up_counter: MODULUS 64 and 10 instances
// on shared stimulus, checked against an arithmetic model.
module tb_jk_sync_up_counter;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [5:0] d = '0;
  logic       ovf_clr = 1'b0;

  logic [5:0] a_q, a_qn, b_q, b_qn;
  logic       a_tc, a_ovf, b_tc, b_ovf;

  logic [5:0] oq [2];
  logic [5:0] oqn [2];
  logic       otc [2];
  logic       oovf [2];

  int mq [2];
  int mov [2];
  int mods [2] = '{64, 10};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jk_sync_up_counter #(.WIDTH(6), .MODULUS(64)) u_a (
    .clk(clk), .clr(clr), .en(en), .load(load),
    .d(d), .ovf_clr(ovf_clr),
    .q(a_q), .qnot(a_qn), .tc(a_tc), .ovf(a_ovf)
  );

  jk_sync_up_counter #(.WIDTH(6), .MODULUS(10)) u_b (
    .clk(clk), .clr(clr), .en(en), .load(load),
    .d(d), .ovf_clr(ovf_clr),
    .q(b_q), .qnot(b_qn), .tc(b_tc), .ovf(b_ovf)
  );

  always_comb begin
    oq[0] = a_q;  oqn[0] = a_qn;
    otc[0] = a_tc; oovf[0] = a_ovf;
    oq[1] = b_q;  oqn[1] = b_qn;
    otc[1] = b_tc; oovf[1] = b_ovf;
  end

  function automatic logic exp_tc(input int k);
    return en && (mq[k] >= mods[k] - 1);
  endfunction

  task automatic apply(input logic c, input logic l,
                       input logic e, input int dv,
                       input logic oc);
    clr = c; load = l; en = e;
    d = 6'(dv); ovf_clr = oc;
    #1;
  endtask

  // one edge: the model follows the rules in plain arithmetic
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit wr;
      wr = 0;
      if (clr) begin
        mq[k] = 0; mov[k] = 0;
      end else begin
        if (load) mq[k] = int'(d);
        else if (en) begin
          if (mq[k] >= mods[k] - 1) begin
            mq[k] = 0; wr = 1;
          end else mq[k] = (mq[k] + 1) % 64;
        end
        if (wr) mov[k] = 1;
        else if (ovf_clr) mov[k] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0);
    tick();
    tick();
    apply(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (oq[k] !== 6'd0 || oqn[k] !== 6'h3F ||
          oovf[k] !== 1'b0 || otc[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset dut%0d: q=%h qn=%h ovf=%b tc=%b want 00 3f 0 0",
                 k, oq[k], oqn[k], oovf[k], otc[k]);
      end
    end
  endtask

  task automatic test_count64();
    for (int i = 0; i < 64; i++) begin
      apply(0, 0, 1, 0, 0);
      n_cmp++;
      if (a_tc !== (i == 63)) begin
        n_bad++;
        $display("FAIL count64 tc at q=%0d: got %b want %b",
                 i, a_tc, (i == 63));
      end
      tick();
      n_cmp++;
      if (a_q !== 6'((i + 1) % 64) || a_qn !== ~a_q ||
          a_ovf !== (i == 63)) begin
        n_bad++;
        $display("FAIL count64 step %0d: q=%0d qn=%h ovf=%b want %0d ~q %b",
                 i, a_q, a_qn, a_ovf, (i + 1) % 64, (i == 63));
      end
    end
  endtask

  task automatic test_load();
    apply(0, 1, 1, 40, 0);
    tick();
    n_cmp++;
    if (a_q !== 6'd40) begin
      n_bad++;
      $display("FAIL load_wins: got %0d want 40", a_q);
    end
    apply(0, 0, 1, 0, 0);
    tick();
    n_cmp++;
    if (a_q !== 6'd41) begin
      n_bad++;
      $display("FAIL load_then_count: got %0d want 41", a_q);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (a_q !== 6'd41 || a_qn !== 6'd22) begin
        n_bad++;
        $display("FAIL hold %0d: got q=%0d qn=%0d want 41 22",
                 i, a_q, a_qn);
      end
    end
  endtask

  task automatic test_wrap_vs_ovf_clr();
    apply(0, 1, 0, 63, 1);
    tick();
    apply(0, 0, 1, 0, 1);
    n_cmp++;
    if (a_tc !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_tc: got %b want 1", a_tc);
    end
    tick();
    n_cmp++;
    if (a_q !== 6'd0 || a_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_beats_clr: q=%0d ovf=%b want 0 1",
               a_q, a_ovf);
    end
    apply(0, 0, 0, 0, 1);
    tick();
    n_cmp++;
    if (a_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clr: got %b want 0", a_ovf);
    end
  endtask

  task automatic test_clr_priority();
    apply(0, 1, 0, 24, 0);
    tick();
    apply(0, 0, 1, 0, 0);
    tick();
    n_cmp++;
    if (a_q !== 6'd25) begin
      n_bad++;
      $display("FAIL pre_clr: got %0d want 25", a_q);
    end
    apply(1, 1, 1, 7, 0);
    tick();
    n_cmp++;
    if (a_q !== 6'd0 || a_qn !== 6'h3F) begin
      n_bad++;
      $display("FAIL clr_over_load: q=%0d qn=%h want 0 3f",
               a_q, a_qn);
    end
  endtask

  task automatic test_mod10();
    apply(1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, 1, 0, 0);
      n_cmp++;
      if (b_tc !== ((i % 10) == 9)) begin
        n_bad++;
        $display("FAIL mod10 tc step %0d: got %b want %b",
                 i, b_tc, ((i % 10) == 9));
      end
      tick();
      n_cmp++;
      if (b_q !== 6'((i + 1) % 10) || b_qn !== ~b_q) begin
        n_bad++;
        $display("FAIL mod10 q step %0d: q=%0d qn=%h want %0d",
                 i, b_q, b_qn, (i + 1) % 10);
      end
    end
    apply(0, 1, 0, 12, 1);
    tick();
    n_cmp++;
    if (b_q !== 6'd12 || b_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL mod10 load12: q=%0d ovf=%b want 12 0",
               b_q, b_ovf);
    end
    apply(0, 0, 1, 0, 0);
    n_cmp++;
    if (b_tc !== 1'b1) begin
      n_bad++;
      $display("FAIL mod10 tc_oor: got %b want 1", b_tc);
    end
    tick();
    n_cmp++;
    if (b_q !== 6'd0 || b_ovf !== 1'b1 || b_qn !== 6'h3F) begin
      n_bad++;
      $display("FAIL mod10 oor_wrap: q=%0d ovf=%b qn=%h want 0 1 3f",
               b_q, b_ovf, b_qn);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(31) == 0),
            ($urandom_range(7) == 0),
            ($urandom_range(3) != 0),
            int'($urandom_range(63)),
            ($urandom_range(7) == 0));
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (otc[k] !== exp_tc(k)) begin
          n_bad++;
          $display("FAIL rand tc dut%0d cyc %0d: got %b want %b",
                   k, n, otc[k], exp_tc(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (oq[k] !== 6'(mq[k]) || oqn[k] !== ~6'(mq[k]) ||
            oovf[k] !== mov[k][0]) begin
          n_bad++;
          $display("FAIL rand dut%0d cyc %0d: q=%0d qn=%h ovf=%b want %0d %h %0d",
                   k, n, oq[k], oqn[k], oovf[k],
                   mq[k], ~6'(mq[k]), mov[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count64();
    test_load();
    test_wrap_vs_ovf_clr();
    test_clr_priority();
    test_mod10();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
